// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler that time-shares one combinational add/sub unit between
// NREQ requesters: latch operands, let the unit settle, capture, and respond.
module fp_addsub_sched #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned EXP_BITS    = 8,
  parameter int unsigned SIG_BITS    = 23,
  parameter int unsigned WAIT_CYCLES = 2,
  localparam int unsigned FW         = 1 + EXP_BITS + SIG_BITS,
  localparam int unsigned IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FW-1:0]   req_op_a,
  input  logic [NREQ*FW-1:0]   req_op_b,
  input  logic [NREQ-1:0]      req_opcode,
  output logic                 sign1,
  output logic                 sign2,
  output logic [EXP_BITS-1:0]  exp1,
  output logic [EXP_BITS-1:0]  exp2,
  output logic [SIG_BITS-1:0]  sig1,
  output logic [SIG_BITS-1:0]  sig2,
  output logic                 opcode,
  input  logic [FW-1:0]        fp_out,
  input  logic [2:0]           err_o,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [FW-1:0]        resp_result,
  output logic [2:0]           resp_err,
  output logic                 busy
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  idx;
  logic            grant_vld;
  logic [CW-1:0]   cnt;
  logic [FW-1:0]   op_a_sel, op_b_sel;
  logic            op_sel;
  logic            accept;
  logic            capture;

  // Scan starts just after the last winner, so a held request waits at most NREQ-1 ops.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    op_a_sel  = '0;
    op_b_sel  = '0;
    op_sel    = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDW'((32'(last) + i) % NREQ);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        op_a_sel = req_op_a[i*FW +: FW];
        op_b_sel = req_op_b[i*FW +: FW];
        op_sel   = req_opcode[i];
      end
    end
  end

  assign accept     = (state == IDLE) && grant_vld;
  assign capture    = (state == EXEC) && (cnt == '0);
  assign req_ready  = accept ? (NREQ'(1) << grant) : '0;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld)  state_nxt = EXEC;
      EXEC:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign1       <= 1'b0;
      exp1        <= '0;
      sig1        <= '0;
      sign2       <= 1'b0;
      exp2        <= '0;
      sig2        <= '0;
      opcode      <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_err    <= '0;
      last        <= IDW'(NREQ - 1);
      cnt         <= '0;
    end else begin
      if (accept) begin
        sign1   <= op_a_sel[FW-1];
        exp1    <= op_a_sel[FW-2 -: EXP_BITS];
        sig1    <= op_a_sel[SIG_BITS-1:0];
        sign2   <= op_b_sel[FW-1];
        exp2    <= op_b_sel[FW-2 -: EXP_BITS];
        sig2    <= op_b_sel[SIG_BITS-1:0];
        opcode  <= op_sel;
        resp_id <= grant;
        last    <= grant;
        cnt     <= CW'(WAIT_CYCLES - 1);
      end else if ((state == EXEC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        resp_result <= fp_out;
        resp_err    <= err_o;
      end
    end
  end

endmodule

// File: doc/fp_addsub_sched.md
Name: fp_addsub_sched

Overview:
- Round-robin scheduler that shares one combinational add_sub_top datapath between NREQ requesters.
- Accepts a request over a valid/ready handshake and latches its operands onto the unit's operand ports.
- Holds the operands stable for WAIT_CYCLES cycles so the combinational adder settles, captures fp_out/err_o, and returns the result with a requester ID over a valid/ready response channel.
- Sits between FPU issue logic and the add/sub unit.

Parameters:
NREQ, 2, number of requesters (≥2)
EXP_BITS, 8, exponent width
SIG_BITS, 23, stored significand width
WAIT_CYCLES, 2, cycles operands are held before capture (≥1)
(derived) FW = 1+EXP_BITS+SIG_BITS; IDW = max(1,$clog2(NREQ))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_op_a  in  NREQ*FW  operand A, slice i = requester i, {sign,exp,sig}
req_op_b  in  NREQ*FW  operand B, same packing
req_opcode  in  NREQ  0=A+B, 1=A−B
sign1, sign2  out  1  to unit
exp1, exp2  out  EXP_BITS  to unit
sig1, sig2  out  SIG_BITS  to unit
opcode  out  1  to unit
fp_out  in  FW  unit result
err_o  in  3  unit error code (o_err_t)
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  IDW  index of the requester served
resp_result  out  FW  captured fp_out
resp_err  out  3  captured err_o
busy  out  1  state != IDLE

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state = IDLE
  - all unit operand outputs = 0
  - resp_valid = 0, resp_id = 0, resp_result = 0, resp_err = 0, busy = 0
  - round-robin pointer last = NREQ-1, so requester 0 wins first
  - wait counter = 0
- Reset asserted mid-operation: abandons the in-flight op immediately. No response is produced for it.
- Arbitration, evaluated in IDLE only:
  - grant = first i with req_valid[i]=1, scanning last+1, last+2, … mod NREQ.
  - req_ready[grant] = 1 combinationally in that cycle. Every other req_ready bit = 0.
  - req_ready = 0 in every bit outside IDLE.
  - Requesters must hold valid and operands until ready. Acceptance = valid&ready in the same cycle.
- On accept (cycle k):
  - Register operands onto sign1/exp1/sig1/sign2/exp2/sig2/opcode.
  - Record resp_id = grant and set last = grant.
  - Set counter = WAIT_CYCLES-1 and move to EXEC.
- EXEC:
  - Operand outputs are held constant.
  - Counter decrements each cycle. In the cycle counter==0, capture fp_out→resp_result and err_o→resp_err, then move to RESP.
  - resp_valid first goes high in cycle k+WAIT_CYCLES+1.
- RESP:
  - resp_valid=1; resp_id, resp_result and resp_err are stable.
  - On resp_valid&resp_ready: go to IDLE and drop resp_valid next cycle.
  - resp_ready low: remain in RESP indefinitely (back-pressure).
- No overlap: a new grant can occur at earliest the cycle after the response handshake. Minimum period per op = WAIT_CYCLES+2 cycles.
- Outside EXEC, unit operand outputs retain their last values (no toggling).
- Simultaneous valids: exactly one grant per IDLE cycle. Starvation-free: a continuously valid requester waits at most NREQ-1 other ops.
- req_valid dropping without acceptance is legal and ignored.
- resp_ready while not in RESP is ignored.
- Pointer wrap: last = NREQ-1 → next scan starts at 0.

Test Plan:
1. Single op: req 0 valid, A=0x3F800000 (1.0), B=0x40000000 (2.0), opcode 0, WAIT_CYCLES=2, resp_ready=1 → req_ready[0] in cycle k; resp_valid in cycle k+3 with resp_result=0x40400000 (3.0), resp_id=0, resp_err = unit's no-error code; busy high cycles k+1..k+3.
2. Subtract: req 1, A=0x40400000, B=0x3F800000, opcode 1 → resp_result=0x40000000 (2.0), resp_id=1; unit opcode pin =1 throughout EXEC.
3. Contention: both requesters valid continuously from reset → grant order 0,1,0,1; each req_ready one-hot; never both high.
4. Back-pressure: resp_ready=0 for 5 cycles after resp_valid → resp_valid and resp_result held, req_ready stays 0 despite pending req 1; resp_ready=1 → IDLE next cycle, req 1 granted the following cycle.
5. Special values: A=0x7F800000 (+inf), B=0xFF800000 (−inf), opcode 0 → resp_result and resp_err equal the unit's fp_out/err_o sampled at capture (NaN plus invalid code), checked against the FloatingPoint reference model.
6. Reset mid-EXEC: drop rst_n one cycle after accept → all outputs zero immediately; after release, no stale resp_valid, and requester 0 has priority again.
